// File: rtl/ahb_interconnect_m2s2.sv
// AHB interconnect for two masters and two slaves. It contains a round-robin
// arbiter with bus request/grant and a registered address-phase master mux.
// It also has the data-phase write-data mux, an address decoder with region
// remap, the slave response mux, and a default slave for unmapped addresses.
module ahb_interconnect_m2s2 #(
    parameter int          P_NUMM        = 2,
    parameter int          P_NUMS        = 2,
    parameter logic [31:0] P_HSEL0_START = 32'h0,
    parameter logic [31:0] P_HSEL0_SIZE  = 32'h400,
    parameter logic [31:0] P_HSEL1_START = 32'h400,
    parameter logic [31:0] P_HSEL1_SIZE  = 32'h400
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        M0_HBUSREQ,
    input  logic        M1_HBUSREQ,
    output logic        M0_HGRANT,
    output logic        M1_HGRANT,
    input  logic [31:0] M0_HADDR,
    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic [1:0]  M1_HTRANS,
    input  logic [2:0]  M0_HSIZE,
    input  logic [2:0]  M1_HSIZE,
    input  logic [2:0]  M0_HBURST,
    input  logic [2:0]  M1_HBURST,
    input  logic [3:0]  M0_HPROT,
    input  logic [3:0]  M1_HPROT,
    input  logic        M0_HLOCK,
    input  logic        M1_HLOCK,
    input  logic        M0_HWRITE,
    input  logic        M1_HWRITE,
    input  logic [31:0] M0_HWDATA,
    input  logic [31:0] M1_HWDATA,
    output logic [31:0] M_HRDATA,
    output logic [1:0]  M_HRESP,
    output logic        M_HREADY,
    output logic [31:0] S_HADDR,
    output logic        S_HWRITE,
    output logic [1:0]  S_HTRANS,
    output logic [2:0]  S_HSIZE,
    output logic [2:0]  S_HBURST,
    output logic [3:0]  S_HPROT,
    output logic [31:0] S_HWDATA,
    output logic        S_HREADY,
    output logic [3:0]  S_HMASTER,
    output logic        S_HMASTLOCK,
    output logic        S0_HSEL,
    output logic        S1_HSEL,
    input  logic        S0_HREADY,
    input  logic        S1_HREADY,
    input  logic [1:0]  S0_HRESP,
    input  logic [1:0]  S1_HRESP,
    input  logic [31:0] S0_HRDATA,
    input  logic [31:0] S1_HRDATA,
    input  logic [15:0] S0_HSPLIT,
    input  logic [15:0] S1_HSPLIT,
    input  logic        REMAP
);

    localparam logic [1:0] TRANS_IDLE = 2'd0;
    localparam logic [1:0] RESP_OKAY  = 2'd0;
    localparam logic [1:0] RESP_ERROR = 2'd2;
    localparam logic [1:0] SLV_0      = 2'd0;
    localparam logic [1:0] SLV_1      = 2'd1;
    localparam logic [1:0] SLV_DEF    = 2'd2;

    localparam logic [31:0] REGION_START [P_NUMS] = '{P_HSEL0_START, P_HSEL1_START};
    localparam logic [31:0] REGION_SIZE  [P_NUMS] = '{P_HSEL0_SIZE, P_HSEL1_SIZE};

    // Master-side signals gathered into arrays indexed by master number.
    logic        m_busreq [P_NUMM];
    logic [31:0] m_haddr  [P_NUMM];
    logic [1:0]  m_htrans [P_NUMM];
    logic [2:0]  m_hsize  [P_NUMM];
    logic [2:0]  m_hburst [P_NUMM];
    logic [3:0]  m_hprot  [P_NUMM];
    logic        m_hlock  [P_NUMM];
    logic        m_hwrite [P_NUMM];
    logic [31:0] m_hwdata [P_NUMM];

    assign m_busreq[0] = M0_HBUSREQ;
    assign m_busreq[1] = M1_HBUSREQ;
    assign m_haddr[0]  = M0_HADDR;
    assign m_haddr[1]  = M1_HADDR;
    assign m_htrans[0] = M0_HTRANS;
    assign m_htrans[1] = M1_HTRANS;
    assign m_hsize[0]  = M0_HSIZE;
    assign m_hsize[1]  = M1_HSIZE;
    assign m_hburst[0] = M0_HBURST;
    assign m_hburst[1] = M1_HBURST;
    assign m_hprot[0]  = M0_HPROT;
    assign m_hprot[1]  = M1_HPROT;
    assign m_hlock[0]  = M0_HLOCK;
    assign m_hlock[1]  = M1_HLOCK;
    assign m_hwrite[0] = M0_HWRITE;
    assign m_hwrite[1] = M1_HWRITE;
    assign m_hwdata[0] = M0_HWDATA;
    assign m_hwdata[1] = M1_HWDATA;

    // Split-resume vectors are not used: SPLIT/RETRY are never issued here.
    logic unused_split;
    assign unused_split = ^{S0_HSPLIT, S1_HSPLIT};

    logic       grant_reg, grant_next;
    logic       owner_reg;
    logic       dmaster_reg;
    logic       mastlock_reg;
    logic [1:0] dslave_reg;
    logic       def_req_reg;
    logic       def_second_reg;
    logic       bus_ready;
    logic       other_m;
    logic       hold_grant;
    logic [P_NUMS-1:0] region_hit;
    logic [1:0] addr_slave;
    logic       def_hready;
    logic [1:0] def_hresp;

    // Address-phase mux driven by the registered address owner.
    assign S_HADDR     = m_haddr[owner_reg];
    assign S_HTRANS    = m_htrans[owner_reg];
    assign S_HWRITE    = m_hwrite[owner_reg];
    assign S_HSIZE     = m_hsize[owner_reg];
    assign S_HBURST    = m_hburst[owner_reg];
    assign S_HPROT     = m_hprot[owner_reg];
    assign S_HMASTER   = {3'b000, owner_reg};
    assign S_HMASTLOCK = mastlock_reg;
    assign S_HWDATA    = m_hwdata[dmaster_reg];
    assign M0_HGRANT   = ~grant_reg;
    assign M1_HGRANT   = grant_reg;

    // Region hit: offset from the region base below the region size.
    generate
        for (genvar gi = 0; gi < P_NUMS; gi++) begin : g_region
            assign region_hit[gi] = (S_HADDR - REGION_START[gi]) < REGION_SIZE[gi];
        end
    endgenerate

    // Decoder: swap the slave selects under REMAP, fall back to the default slave.
    always_comb begin
        S0_HSEL    = REMAP ? (region_hit[1] & ~region_hit[0]) : region_hit[0];
        S1_HSEL    = REMAP ? region_hit[0] : (region_hit[1] & ~region_hit[0]);
        addr_slave = SLV_DEF;
        if (S0_HSEL) begin
            addr_slave = SLV_0;
        end else if (S1_HSEL) begin
            addr_slave = SLV_1;
        end
    end

    // Default slave: a two-cycle ERROR for active transfers, otherwise OKAY.
    always_comb begin
        def_hready = ~(def_req_reg & ~def_second_reg);
        def_hresp  = def_req_reg ? RESP_ERROR : RESP_OKAY;
    end

    // Response mux selected by the data-phase slave.
    always_comb begin
        M_HRDATA = 32'h0;
        M_HRESP  = def_hresp;
        M_HREADY = def_hready;
        case (dslave_reg)
            SLV_0: begin
                M_HRDATA = S0_HRDATA;
                M_HRESP  = S0_HRESP;
                M_HREADY = S0_HREADY;
            end
            SLV_1: begin
                M_HRDATA = S1_HRDATA;
                M_HRESP  = S1_HRESP;
                M_HREADY = S1_HREADY;
            end
            default: ;
        endcase
    end

    assign bus_ready = M_HREADY;
    assign S_HREADY  = M_HREADY;

    // Round-robin arbitration: hold while locked or while the grantee is still transferring.
    always_comb begin
        other_m    = ~grant_reg;
        hold_grant = mastlock_reg | m_hlock[grant_reg] |
                     (m_busreq[grant_reg] & (m_htrans[grant_reg] != TRANS_IDLE));
        grant_next = grant_reg;
        if (!hold_grant && m_busreq[other_m]) begin
            grant_next = other_m;
        end
    end

    // Grant, address owner and lock flag advance only on ready edges.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_reg    <= 1'b0;
            owner_reg    <= 1'b0;
            mastlock_reg <= 1'b0;
        end else if (bus_ready) begin
            grant_reg    <= grant_next;
            owner_reg    <= grant_reg;
            mastlock_reg <= m_hlock[grant_reg];
        end
    end

    // Data-phase master and slave captured from the completing address phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dmaster_reg <= 1'b0;
            dslave_reg  <= SLV_DEF;
        end else if (bus_ready) begin
            dmaster_reg <= owner_reg;
            dslave_reg  <= addr_slave;
        end
    end

    // Default-slave sequencing: arm on an active unmapped transfer, then step to the second cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            def_req_reg    <= 1'b0;
            def_second_reg <= 1'b0;
        end else if (bus_ready) begin
            def_req_reg    <= (addr_slave == SLV_DEF) & S_HTRANS[1];
            def_second_reg <= 1'b0;
        end else if (def_req_reg) begin
            def_second_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ahb_interconnect_m2s2.sv
// Bench for ahb_interconnect_m2s2: two memory slaves with programmable wait
// states, directed and random transfers checked against a reference model.
module tb_ahb_interconnect_m2s2;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        m_busreq [2];
    logic [31:0] m_haddr  [2];
    logic [1:0]  m_htrans [2];
    logic [2:0]  m_hsize  [2];
    logic [2:0]  m_hburst [2];
    logic [3:0]  m_hprot  [2];
    logic        m_hlock  [2];
    logic        m_hwrite [2];
    logic [31:0] m_hwdata [2];
    logic        M0_HGRANT, M1_HGRANT;
    logic [31:0] M_HRDATA;
    logic [1:0]  M_HRESP;
    logic        M_HREADY;
    logic [31:0] S_HADDR, S_HWDATA;
    logic        S_HWRITE, S_HREADY, S_HMASTLOCK;
    logic [1:0]  S_HTRANS;
    logic [2:0]  S_HSIZE, S_HBURST;
    logic [3:0]  S_HPROT, S_HMASTER;
    logic        S0_HSEL, S1_HSEL, S0_HREADY, S1_HREADY;
    logic [1:0]  S0_HRESP, S1_HRESP;
    logic [31:0] S0_HRDATA, S1_HRDATA;
    logic [15:0] S0_HSPLIT, S1_HSPLIT;
    logic        REMAP;
    logic [1:0]  grant_vec;

    int n_checks = 0;
    int n_errors = 0;

    // Slave environment state
    logic [31:0] slv_mem [2][256];
    logic        sv_valid [2];
    logic        sv_write [2];
    logic [7:0]  sv_word  [2];
    int          sv_cnt   [2];
    int          wait_cfg [2];
    logic [1:0]  s_hsel;

    // Reference memory, indexed by physical slave and word offset
    logic [31:0] ref_mem [2][256];

    always #5 HCLK = ~HCLK;

    assign grant_vec = {M1_HGRANT, M0_HGRANT};
    assign s_hsel    = {S1_HSEL, S0_HSEL};
    assign S0_HSPLIT = 16'h0;
    assign S1_HSPLIT = 16'h0;
    assign S0_HRESP  = 2'd0;
    assign S1_HRESP  = 2'd0;
    assign S0_HREADY = !(sv_valid[0] && sv_cnt[0] != 0);
    assign S1_HREADY = !(sv_valid[1] && sv_cnt[1] != 0);
    assign S0_HRDATA = slv_mem[0][sv_word[0]];
    assign S1_HRDATA = slv_mem[1][sv_word[1]];

    ahb_interconnect_m2s2 dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .M0_HBUSREQ  (m_busreq[0]),
        .M1_HBUSREQ  (m_busreq[1]),
        .M0_HGRANT   (M0_HGRANT),
        .M1_HGRANT   (M1_HGRANT),
        .M0_HADDR    (m_haddr[0]),
        .M1_HADDR    (m_haddr[1]),
        .M0_HTRANS   (m_htrans[0]),
        .M1_HTRANS   (m_htrans[1]),
        .M0_HSIZE    (m_hsize[0]),
        .M1_HSIZE    (m_hsize[1]),
        .M0_HBURST   (m_hburst[0]),
        .M1_HBURST   (m_hburst[1]),
        .M0_HPROT    (m_hprot[0]),
        .M1_HPROT    (m_hprot[1]),
        .M0_HLOCK    (m_hlock[0]),
        .M1_HLOCK    (m_hlock[1]),
        .M0_HWRITE   (m_hwrite[0]),
        .M1_HWRITE   (m_hwrite[1]),
        .M0_HWDATA   (m_hwdata[0]),
        .M1_HWDATA   (m_hwdata[1]),
        .M_HRDATA    (M_HRDATA),
        .M_HRESP     (M_HRESP),
        .M_HREADY    (M_HREADY),
        .S_HADDR     (S_HADDR),
        .S_HWRITE    (S_HWRITE),
        .S_HTRANS    (S_HTRANS),
        .S_HSIZE     (S_HSIZE),
        .S_HBURST    (S_HBURST),
        .S_HPROT     (S_HPROT),
        .S_HWDATA    (S_HWDATA),
        .S_HREADY    (S_HREADY),
        .S_HMASTER   (S_HMASTER),
        .S_HMASTLOCK (S_HMASTLOCK),
        .S0_HSEL     (S0_HSEL),
        .S1_HSEL     (S1_HSEL),
        .S0_HREADY   (S0_HREADY),
        .S1_HREADY   (S1_HREADY),
        .S0_HRESP    (S0_HRESP),
        .S1_HRESP    (S1_HRESP),
        .S0_HRDATA   (S0_HRDATA),
        .S1_HRDATA   (S1_HRDATA),
        .S0_HSPLIT   (S0_HSPLIT),
        .S1_HSPLIT   (S1_HSPLIT),
        .REMAP       (REMAP)
    );

    // Two memory slaves with a programmable number of wait states per transfer.
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int s = 0; s < 2; s++) begin
                sv_valid[s] <= 1'b0;
                sv_write[s] <= 1'b0;
                sv_word[s]  <= 8'h0;
                sv_cnt[s]   <= 0;
                for (int w = 0; w < 256; w++) slv_mem[s][w] <= 32'h0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (S_HREADY) begin
                    if (sv_valid[s] && sv_write[s]) slv_mem[s][sv_word[s]] <= S_HWDATA;
                    sv_valid[s] <= s_hsel[s] && S_HTRANS[1];
                    sv_write[s] <= S_HWRITE;
                    sv_word[s]  <= S_HADDR[9:2];
                    sv_cnt[s]   <= wait_cfg[s];
                end else if (sv_valid[s] && sv_cnt[s] != 0) begin
                    sv_cnt[s] <= sv_cnt[s] - 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Address map: region 0 = [0x000,0x400), region 1 = [0x400,0x800); REMAP swaps slaves.
    function automatic int exp_slave(input logic [31:0] a, input logic rm);
        if (a < 32'h400) return rm ? 1 : 0;
        if (a < 32'h800) return rm ? 0 : 1;
        return 2;
    endfunction

    // One single transfer from master m: request, address phase, data phase, checks.
    task automatic xfer(input int m, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic other_req);
        int exp_slv, exp_wait, waits, guard;
        logic [7:0] word;
        logic g0;
        logic [3:0] hm0, prot;
        exp_slv  = exp_slave(addr, REMAP);
        word     = 8'((addr % 32'h400) >> 2);
        exp_wait = (exp_slv == 2) ? 1 : wait_cfg[exp_slv];
        prot     = (m == 0) ? 4'h3 : 4'hA;
        @(negedge HCLK);
        m_busreq[m]     = 1'b1;
        m_busreq[1 - m] = other_req;
        guard = 0;
        while (!(grant_vec[m] && M_HREADY)) begin
            @(negedge HCLK);
            guard++;
            if (guard > 20) begin
                chk("grant_wait", 32'd0, 32'd1);
                m_busreq[0] = 1'b0;
                m_busreq[1] = 1'b0;
                return;
            end
        end
        @(negedge HCLK);
        m_busreq[m] = 1'b0;
        m_haddr[m]  = addr;
        m_htrans[m] = 2'd2;
        m_hwrite[m] = wr;
        m_hsize[m]  = 3'd2;
        m_hburst[m] = 3'd0;
        m_hprot[m]  = prot;
        #1;
        chk("addr_hmaster", 32'(S_HMASTER), 32'(m));
        chk("addr_haddr", S_HADDR, addr);
        chk("addr_hprot", 32'(S_HPROT), 32'(prot));
        chk("addr_hsize", 32'(S_HSIZE), 32'd2);
        chk("addr_hsel0", 32'(S0_HSEL), 32'(exp_slv == 0));
        chk("addr_hsel1", 32'(S1_HSEL), 32'(exp_slv == 1));
        @(negedge HCLK);
        m_htrans[m] = 2'd0;
        m_hwdata[m] = wdata;
        #1;
        g0  = M1_HGRANT;
        hm0 = S_HMASTER;
        if (exp_slv == 2) chk("def_first_resp", 32'(M_HRESP), 32'd2);
        waits = 0;
        while (!M_HREADY && waits < 20) begin
            chk("stall_grant", 32'(M1_HGRANT), 32'(g0));
            chk("stall_owner", 32'(S_HMASTER), 32'(hm0));
            waits++;
            @(negedge HCLK);
            #1;
        end
        chk("wait_states", 32'(waits), 32'(exp_wait));
        chk("data_hresp", 32'(M_HRESP), (exp_slv == 2) ? 32'd2 : 32'd0);
        if (wr) begin
            chk("data_hwdata", S_HWDATA, wdata);
            if (exp_slv != 2) ref_mem[exp_slv][word] = wdata;
        end else begin
            chk("data_hrdata", M_HRDATA, (exp_slv == 2) ? 32'h0 : ref_mem[exp_slv][word]);
        end
        m_busreq[1 - m] = 1'b0;
        $display("xfer m=%0d %s addr=%h remap=%0d slave=%0d waits=%0d data=%h",
                 m, wr ? "WR" : "RD", addr, REMAP, exp_slv, waits, wr ? wdata : M_HRDATA);
    endtask

    // Arbitration: alternation, locking, parking and single-requester behaviour.
    task automatic arb_test();
        logic prev;
        int   g, moved;
        @(negedge HCLK);
        m_busreq[0] = 1'b1;
        m_busreq[1] = 1'b1;
        prev = M1_HGRANT;
        for (int i = 0; i < 6; i++) begin
            @(negedge HCLK);
            chk("arb_alternate", 32'(M1_HGRANT), 32'(!prev));
            chk("arb_onehot", 32'(M0_HGRANT ^ M1_HGRANT), 32'd1);
            chk("arb_nolock", 32'(S_HMASTLOCK), 32'd0);
            prev = M1_HGRANT;
        end
        $display("arb alternate: 6 edges, last grant m%0d", prev);
        g = int'(M1_HGRANT);
        m_hlock[g] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            chk("lock_grant", 32'(grant_vec[g]), 32'd1);
            chk("lock_mastlock", 32'(S_HMASTLOCK), 32'd1);
        end
        m_hlock[g] = 1'b0;
        moved = 0;
        prev  = M1_HGRANT;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            if (M1_HGRANT != prev) moved++;
            prev = M1_HGRANT;
        end
        chk("unlock_mastlock", 32'(S_HMASTLOCK), 32'd0);
        chk("unlock_regrant", 32'(moved > 0), 32'd1);
        $display("arb lock: m%0d held 4 edges, released moved=%0d", g, moved);
        m_busreq[0] = 1'b0;
        m_busreq[1] = 1'b0;
        @(negedge HCLK);
        prev = M1_HGRANT;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            chk("arb_park", 32'(M1_HGRANT), 32'(prev));
        end
        m_busreq[prev] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge HCLK);
            chk("arb_owner_only", 32'(M1_HGRANT), 32'(prev));
        end
        m_busreq[prev]  = 1'b0;
        m_busreq[!prev] = 1'b1;
        @(negedge HCLK);
        chk("arb_other_only", 32'(M1_HGRANT), 32'(!prev));
        m_busreq[0] = 1'b0;
        m_busreq[1] = 1'b0;
        $display("arb park/single-request checks done, grant m%0d", M1_HGRANT);
    endtask

    // Reset during the stalled first cycle of a default-slave ERROR.
    task automatic reset_mid_test();
        int guard;
        @(negedge HCLK);
        m_busreq[1] = 1'b1;
        guard = 0;
        while (!M1_HGRANT && guard < 10) begin
            @(negedge HCLK);
            guard++;
        end
        chk("rst_m1_grant", 32'(M1_HGRANT), 32'd1);
        @(negedge HCLK);
        m_busreq[1] = 1'b0;
        m_haddr[1]  = 32'h800;
        m_htrans[1] = 2'd2;
        #1;
        chk("rst_owner_m1", 32'(S_HMASTER), 32'd1);
        @(negedge HCLK);
        m_htrans[1] = 2'd0;
        #1;
        chk("rst_pre_stall", 32'(M_HREADY), 32'd0);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("rst_mid_hready", 32'(M_HREADY), 32'd1);
        chk("rst_mid_hresp", 32'(M_HRESP), 32'd0);
        chk("rst_mid_grant0", 32'(M0_HGRANT), 32'd1);
        chk("rst_mid_hmaster", 32'(S_HMASTER), 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        $display("reset mid-transfer: bus returned to reset state");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int r;
        HRESETn = 1'b0;
        REMAP   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_busreq[i] = 1'b0;
            m_haddr[i]  = 32'h0;
            m_htrans[i] = 2'd0;
            m_hsize[i]  = 3'd0;
            m_hburst[i] = 3'd0;
            m_hprot[i]  = 4'd0;
            m_hlock[i]  = 1'b0;
            m_hwrite[i] = 1'b0;
            m_hwdata[i] = 32'h0;
            wait_cfg[i] = 0;
            for (int w = 0; w < 256; w++) ref_mem[i][w] = 32'h0;
        end
        @(negedge HCLK);
        @(negedge HCLK);
        chk("reset_grant0", 32'(M0_HGRANT), 32'd1);
        chk("reset_grant1", 32'(M1_HGRANT), 32'd0);
        chk("reset_hready", 32'(M_HREADY), 32'd1);
        chk("reset_hresp", 32'(M_HRESP), 32'd0);
        chk("reset_hmaster", 32'(S_HMASTER), 32'd0);
        chk("reset_mastlock", 32'(S_HMASTLOCK), 32'd0);
        chk("reset_s_hready", 32'(S_HREADY), 32'd1);
        HRESETn = 1'b1;
        $display("reset state checked");

        reset_mid_test();

        xfer(0, 32'h10, 1'b1, 32'hA5A5_0001, 1'b0);
        xfer(0, 32'h10, 1'b0, 32'h0, 1'b0);
        xfer(1, 32'h404, 1'b1, 32'h1234_5678, 1'b0);
        xfer(1, 32'h404, 1'b0, 32'h0, 1'b0);
        xfer(0, 32'h800, 1'b0, 32'h0, 1'b0);
        xfer(1, 32'h800, 1'b1, 32'hDEAD_BEEF, 1'b0);

        arb_test();

        REMAP       = 1'b1;
        wait_cfg[1] = 3;
        xfer(0, 32'h10, 1'b1, 32'h5A5A_7777, 1'b1);
        xfer(0, 32'h10, 1'b0, 32'h0, 1'b1);
        wait_cfg[1] = 0;

        for (int t = 0; t < 40; t++) begin
            r = int'($urandom_range(0, 5));
            if (r <= 2)      a = 32'($urandom_range(0, 15)) << 2;
            else if (r <= 4) a = 32'h400 + (32'($urandom_range(0, 15)) << 2);
            else             a = 32'h800 + (32'($urandom_range(0, 1023)) << 2);
            REMAP       = 1'($urandom_range(0, 1));
            wait_cfg[0] = int'($urandom_range(0, 3));
            wait_cfg[1] = int'($urandom_range(0, 3));
            xfer(int'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
